// File: rtl/tube_write_buffer_pkg.sv
// Purpose: shared constants, request payload and FSM state type for the tube write buffer.
// Ports:   none (package).
package tube_write_buffer_pkg;

  localparam logic [2:0]  TUBE_ADDR_LO = 3'b000;
  localparam logic [2:0]  TUBE_ADDR_HI = 3'b001;
  localparam int unsigned TUBE_TICK    = 2501;
  localparam int unsigned TUBE_ADDR_W  = 3;
  localparam int unsigned TUBE_DATA_W  = 32;
  localparam int unsigned TUBE_REQ_W   = TUBE_ADDR_W + TUBE_DATA_W;

  typedef struct packed {
    logic [TUBE_ADDR_W-1:0] addr;
    logic [TUBE_DATA_W-1:0] data;
  } tube_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } tube_state_t;

  // True for the two addresses the tube actually implements.
  function automatic logic is_tube_addr(input logic [TUBE_ADDR_W-1:0] addr);
    return (addr == TUBE_ADDR_LO) || (addr == TUBE_ADDR_HI);
  endfunction

endpackage

// File: rtl/tube_write_buffer_sync_fifo.sv
// Purpose: small synchronous FIFO; dout shows the head entry whenever !empty.
// Ports:   clk, reset (sync, active-high), push/din write side, pop/dout read side,
//          count (occupancy), full, empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against overrun/underrun so the pointers can never desynchronise.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible through the counted window.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/tube_write_buffer.sv
// Purpose: queues CPU stores for the digital tube and holds each one on the tube port
//          long enough to be sampled; CPU reads are served from shadow registers.
// Ports:   clk, reset (sync, active-high)
//          cpu_we/cpu_addr/cpu_wdata  store strobe, address, data from the bridge
//          cpu_rdata                  read data from shadows (combinational)
//          cpu_stall                  FIFO full, bridge must hold its store
//          overflow                   sticky flag: a store was dropped while stalled
//          busy                       work queued or an entry is being held
//          tube_we/tube_addr/tube_din registered drive to the tube peripheral
module tube_write_buffer
  import tube_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = TUBE_TICK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        overflow,
  output logic        busy,
  output logic        tube_we,
  output logic [2:0]  tube_addr,
  output logic [31:0] tube_din
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);

  tube_state_t       r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_tube_we;
  logic [2:0]        r_tube_addr;
  logic [31:0]       r_tube_din;
  logic [31:0]       r_shadow_lo;
  logic [3:0]        r_shadow_hi;
  logic              r_overflow;

  logic              w_valid_addr;
  logic              w_accept;
  logic              w_hold_done;
  logic              w_pop;
  tube_req_t         w_push_req;
  tube_req_t         w_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  assign w_valid_addr = is_tube_addr(cpu_addr);
  assign w_accept     = cpu_we & w_valid_addr & ~w_fifo_full;
  assign w_push_req   = '{addr: cpu_addr, data: cpu_wdata};
  assign w_hold_done  = (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

  // Pop when idle with work, or at the end of a hold so the next entry follows with no gap.
  assign w_pop = ~w_fifo_empty & ((r_state == ST_IDLE) | w_hold_done);

  sync_fifo #(
    .WIDTH (TUBE_REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_accept),
    .pop   (w_pop),
    .din   (w_push_req),
    .dout  (w_head),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Hold FSM: each popped entry stays on the tube port for HOLD_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hold_cnt  <= '0;
      r_tube_we   <= 1'b0;
      r_tube_addr <= '0;
      r_tube_din  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_tube_we   <= 1'b1;
            r_tube_addr <= w_head.addr;
            r_tube_din  <= w_head.data;
          end
        end
        ST_HOLD: begin
          if (w_hold_done) begin
            if (w_pop) begin
              r_hold_cnt  <= '0;
              r_tube_addr <= w_head.addr;
              r_tube_din  <= w_head.data;
            end else begin
              r_state   <= ST_IDLE;
              r_tube_we <= 1'b0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Shadows track accepted stores immediately; dropped stores only raise overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_lo <= '0;
      r_shadow_hi <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept && (cpu_addr == TUBE_ADDR_LO)) r_shadow_lo <= cpu_wdata;
      if (w_accept && (cpu_addr == TUBE_ADDR_HI)) r_shadow_hi <= cpu_wdata[3:0];
      if (cpu_we && w_valid_addr && w_fifo_full) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    cpu_rdata = '0;
    if (cpu_addr == TUBE_ADDR_LO)      cpu_rdata = r_shadow_lo;
    else if (cpu_addr == TUBE_ADDR_HI) cpu_rdata = {28'b0, r_shadow_hi};
  end

  assign cpu_stall = w_fifo_full;
  assign busy      = (w_fifo_count != '0) | (r_state == ST_HOLD);
  assign overflow  = r_overflow;
  assign tube_we   = r_tube_we;
  assign tube_addr = r_tube_addr;
  assign tube_din  = r_tube_din;

endmodule

// File: tb/tb_tube_write_buffer.sv
// Purpose: directed self-checking bench for tube_write_buffer; one instance with a short
//          hold (8 cycles) for the detailed sequences and one at the default hold period.
module tb_tube_write_buffer;

  logic        clk;
  logic        reset;

  logic        cpu_we;
  logic [2:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        overflow;
  logic        busy;
  logic        tube_we;
  logic [2:0]  tube_addr;
  logic [31:0] tube_din;

  logic        d_we;
  logic [2:0]  d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        d_overflow;
  logic        d_busy;
  logic        d_tube_we;
  logic [2:0]  d_tube_addr;
  logic [31:0] d_tube_din;

  int n_checks = 0;
  int n_fail   = 0;

  tube_write_buffer #(.DEPTH(4), .HOLD_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .overflow  (overflow),
    .busy      (busy),
    .tube_we   (tube_we),
    .tube_addr (tube_addr),
    .tube_din  (tube_din)
  );

  tube_write_buffer dut_def (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (d_we),
    .cpu_addr  (d_addr),
    .cpu_wdata (d_wdata),
    .cpu_rdata (d_rdata),
    .cpu_stall (d_stall),
    .overflow  (d_overflow),
    .busy      (d_busy),
    .tube_we   (d_tube_we),
    .tube_addr (d_tube_addr),
    .tube_din  (d_tube_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [2:0] a, input logic [31:0] d);
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    tick();
    cpu_we    = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    cpu_addr = a;
    #1;
    check_eq(tag, cpu_rdata, exp);
  endtask

  task automatic expect_hold(input string tag, input logic [2:0] a, input logic [31:0] d,
                             input int n);
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_we"},   32'(tube_we),   32'd1);
      check_eq({tag, "_addr"}, 32'(tube_addr), 32'(a));
      check_eq({tag, "_din"},  tube_din,       d);
      tick();
    end
  endtask

  function automatic logic [31:0] vec(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    int n;
    reset = 1'b1; cpu_we = 1'b0; cpu_addr = 3'b000; cpu_wdata = '0;
    d_we = 1'b0; d_addr = 3'b000; d_wdata = '0;
    tick(); tick();

    // Reset values
    check_eq("rst_tube_we",   32'(tube_we),   32'd0);
    check_eq("rst_tube_addr", 32'(tube_addr), 32'd0);
    check_eq("rst_tube_din",  tube_din,       32'd0);
    check_eq("rst_stall",     32'(cpu_stall), 32'd0);
    check_eq("rst_overflow",  32'(overflow),  32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_rdata",     cpu_rdata,      32'd0);
    reset = 1'b0;

    // 1: single store, one-cycle latency, held exactly 8 cycles
    store(3'b000, 32'h1234_5678);
    check_eq("t1_rdata",   cpu_rdata,     32'h1234_5678);
    check_eq("t1_we_lat",  32'(tube_we),  32'd0);
    check_eq("t1_busy",    32'(busy),     32'd1);
    tick();
    expect_hold("t1_hold", 3'b000, 32'h1234_5678, 8);
    check_eq("t1_we_off",  32'(tube_we),  32'd0);
    check_eq("t1_idle",    32'(busy),     32'd0);

    // 2: three stores back to back, strict order, no gaps
    reset = 1'b1; tick(); reset = 1'b0;
    store(3'b000, 32'hA5A5_0001);
    store(3'b001, 32'h0000_000F);
    store(3'b000, 32'h5A5A_0002);
    read_chk("t2_rd_hi", 3'b001, 32'h0000_000F);
    read_chk("t2_rd_lo", 3'b000, 32'h5A5A_0002);
    expect_hold("t2_a", 3'b000, 32'hA5A5_0001, 7);
    expect_hold("t2_f", 3'b001, 32'h0000_000F, 8);
    expect_hold("t2_b", 3'b000, 32'h5A5A_0002, 8);
    check_eq("t2_we_off", 32'(tube_we), 32'd0);

    // 3: six back-to-back stores; one is popped at once, four fill the FIFO, the sixth drops
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cpu_we = 1'b1; cpu_addr = 3'b000; cpu_wdata = vec(i);
      tick();
      check_eq($sformatf("t3_stall%0d", i), 32'(cpu_stall), (i >= 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("t3_ovf%0d", i),   32'(overflow),  (i >= 5) ? 32'd1 : 32'd0);
    end
    cpu_we = 1'b0;
    read_chk("t3_rd_last", 3'b000, vec(4));
    expect_hold("t3_v0", 3'b000, vec(0), 4);
    for (int i = 1; i < 5; i++) expect_hold($sformatf("t3_v%0d", i), 3'b000, vec(i), 8);
    check_eq("t3_we_off", 32'(tube_we), 32'd0);
    check_eq("t3_busy",   32'(busy),    32'd0);

    // 4: store while full on the same edge the hold pops the next entry
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 5; i++) store(3'b000, vec(i));
    tick(); tick(); tick(); tick();
    check_eq("t4_full",    32'(cpu_stall), 32'd1);
    check_eq("t4_head",    tube_din,       vec(0));
    store(3'b000, 32'hDEAD_BEEF);
    check_eq("t4_ovf",     32'(overflow),  32'd1);
    check_eq("t4_unstall", 32'(cpu_stall), 32'd0);
    check_eq("t4_next",    tube_din,       vec(1));
    check_eq("t4_we",      32'(tube_we),   32'd1);
    read_chk("t4_rd", 3'b000, vec(4));

    // 5: drain, then reset in the 3rd hold cycle with two entries queued
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check_eq("t5_drain",   32'(busy),     32'd0);
    check_eq("t5_ovf_pre", 32'(overflow), 32'd1);
    store(3'b000, vec(10));
    store(3'b000, vec(11));
    store(3'b000, vec(12));
    tick();
    check_eq("t5_pre_we",  32'(tube_we), 32'd1);
    check_eq("t5_pre_din", tube_din,     vec(10));
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("t5_we",    32'(tube_we),   32'd0);
    check_eq("t5_busy",  32'(busy),      32'd0);
    check_eq("t5_stall", 32'(cpu_stall), 32'd0);
    check_eq("t5_ovf",   32'(overflow),  32'd0);
    read_chk("t5_rd", 3'b000, 32'd0);

    // 6: store to an unused address is ignored
    store(3'b010, 32'hFFFF_FFFF);
    check_eq("t6_we",   32'(tube_we),  32'd0);
    check_eq("t6_busy", 32'(busy),     32'd0);
    check_eq("t6_ovf",  32'(overflow), 32'd0);
    read_chk("t6_rd_lo",  3'b000, 32'd0);
    read_chk("t6_rd_hi",  3'b001, 32'd0);
    read_chk("t6_rd_bad", 3'b010, 32'd0);
    tick(); tick();
    check_eq("t6_we_late", 32'(tube_we), 32'd0);

    // Default hold period: 2501 cycles on the tube port
    d_we = 1'b1; d_addr = 3'b000; d_wdata = 32'h0BAD_CAFE;
    tick();
    d_we = 1'b0;
    check_eq("def_we_lat", 32'(d_tube_we), 32'd0);
    tick();
    check_eq("def_we",  32'(d_tube_we), 32'd1);
    check_eq("def_din", d_tube_din,     32'h0BAD_CAFE);
    n = 0;
    while (d_tube_we && n < 3000) begin
      n++;
      tick();
    end
    check_eq("def_hold_len", 32'(n), 32'd2501);
    check_eq("def_busy",     32'(d_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
